// File: rtl/csr_bank_mq.sv
// APB-facing CSR bank: operand/ctrl registers packed into a FIFO_IN command,
// result holding register fed from FIFO_OUT, sticky W1C errors and maskable irq.
module csr_bank_mq #(
  parameter int unsigned APB_BUS_SIZE   = 32,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned DATA_SIZE      = 32,
  parameter int unsigned NUM_OPERANDS   = 2,
  parameter int unsigned OPERATION_SIZE = 4,
  parameter int unsigned OPERATION_BIT  = 1,
  parameter int unsigned ID_SIZE        = 4,
  parameter int unsigned ID_BIT         = 5,
  parameter int unsigned FIFO_OUT_WIDTH = 32,
  parameter int unsigned FIFO_IN_WIDTH  = NUM_OPERANDS*DATA_SIZE+ID_SIZE+OPERATION_SIZE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [APB_BUS_SIZE-1:0]   wdata,
  output logic [APB_BUS_SIZE-1:0]   rdata,
  output logic [FIFO_IN_WIDTH-1:0]  fifo_in_data,
  output logic                      fifo_in_push,
  input  logic                      fifo_in_full,
  input  logic [FIFO_OUT_WIDTH-1:0] fifo_out_data,
  input  logic                      fifo_out_empty,
  output logic                      fifo_out_pop,
  output logic                      irq
);

  localparam int unsigned HDR_W = ID_SIZE + OPERATION_SIZE;

  typedef enum logic {IDLE, PEND} state_t;

  state_t                     state, state_next;
  logic [OPERATION_SIZE-1:0]  op;
  logic [ID_SIZE-1:0]         id;
  logic                       auto_id;
  logic [DATA_SIZE-1:0]       data_q [NUM_OPERANDS];
  logic [1:0]                 irq_en;
  logic [FIFO_OUT_WIDTH-1:0]  result;
  logic                       res_valid;
  logic                       cmd_err;
  logic                       rd_underflow;

  logic wr_ctrl, wr_status, wr_irq_en, wr_data_any, rd_result;
  logic cmd_err_set, underflow_set;
  logic unused_bits;

  // Address decode; a simultaneous write suppresses read side effects
  always_comb begin
    wr_data_any = 1'b0;
    for (int unsigned k = 0; k < NUM_OPERANDS; k++) begin
      if (addr == ADDR_W'(4 + k)) wr_data_any = wr_en;
    end
  end

  assign wr_ctrl       = wr_en && (addr == ADDR_W'(0));
  assign wr_status     = wr_en && (addr == ADDR_W'(1));
  assign wr_irq_en     = wr_en && (addr == ADDR_W'(2));
  assign rd_result     = rd_en && !wr_en && (addr == ADDR_W'(3));
  assign cmd_err_set   = (state == PEND) && (wr_ctrl || wr_data_any);
  assign underflow_set = rd_result && !res_valid;
  assign fifo_out_pop  = !res_valid && !fifo_out_empty;
  assign unused_bits   = ^wdata;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Command FSM: hold the snapshot in PEND until FIFO_IN accepts it
  always_comb begin
    state_next   = state;
    fifo_in_push = 1'b0;
    case (state)
      IDLE: if (wr_ctrl && wdata[0]) state_next = PEND;
      PEND: begin
        fifo_in_push = !fifo_in_full;
        if (!fifo_in_full) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op           <= '0;
      id           <= '0;
      auto_id      <= 1'b0;
      irq_en       <= '0;
      result       <= '0;
      res_valid    <= 1'b0;
      cmd_err      <= 1'b0;
      rd_underflow <= 1'b0;
      irq          <= 1'b0;
      for (int unsigned k = 0; k < NUM_OPERANDS; k++) data_q[k] <= '0;
    end else begin
      if (state == IDLE && wr_ctrl) begin
        op      <= wdata[OPERATION_BIT +: OPERATION_SIZE];
        id      <= wdata[ID_BIT +: ID_SIZE];
        auto_id <= wdata[APB_BUS_SIZE-1];
      end else if (fifo_in_push && auto_id) begin
        id <= id + ID_SIZE'(1);
      end
      for (int unsigned k = 0; k < NUM_OPERANDS; k++) begin
        if (state == IDLE && wr_en && addr == ADDR_W'(4 + k)) data_q[k] <= wdata[DATA_SIZE-1:0];
      end
      if (wr_irq_en) irq_en <= wdata[1:0];
      if (fifo_out_pop) begin
        result    <= fifo_out_data;
        res_valid <= 1'b1;
      end else if (rd_result && res_valid) begin
        res_valid <= 1'b0;
      end
      // Set events take precedence over W1C
      if (cmd_err_set)                    cmd_err <= 1'b1;
      else if (wr_status && wdata[4])     cmd_err <= 1'b0;
      if (underflow_set)                  rd_underflow <= 1'b1;
      else if (wr_status && wdata[5])     rd_underflow <= 1'b0;
      irq <= (irq_en[0] & res_valid) | (irq_en[1] & (cmd_err | rd_underflow));
    end
  end

  // Command word: {DATA_{N-1}..DATA_0, id, op}
  always_comb begin
    fifo_in_data = '0;
    fifo_in_data[OPERATION_SIZE-1:0] = op;
    fifo_in_data[OPERATION_SIZE +: ID_SIZE] = id;
    for (int unsigned k = 0; k < NUM_OPERANDS; k++) begin
      fifo_in_data[HDR_W + k*DATA_SIZE +: DATA_SIZE] = data_q[k];
    end
  end

  always_comb begin
    rdata = '0;
    if (addr == ADDR_W'(0)) begin
      rdata[0] = (state == PEND);
      rdata[OPERATION_BIT +: OPERATION_SIZE] = op;
      rdata[ID_BIT +: ID_SIZE] = id;
      rdata[APB_BUS_SIZE-1] = auto_id;
    end else if (addr == ADDR_W'(1)) begin
      rdata[5:0] = {rd_underflow, cmd_err, fifo_out_empty, fifo_in_full, res_valid, (state == PEND)};
    end else if (addr == ADDR_W'(2)) begin
      rdata[1:0] = irq_en;
    end else if (addr == ADDR_W'(3)) begin
      rdata = APB_BUS_SIZE'(result);
    end else begin
      for (int unsigned k = 0; k < NUM_OPERANDS; k++) begin
        if (addr == ADDR_W'(4 + k)) rdata = APB_BUS_SIZE'(data_q[k]);
      end
    end
  end

endmodule

// File: tb/tb_csr_bank_mq.sv
// Directed self-checking bench for csr_bank_mq with default parameters.
module tb_csr_bank_mq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [71:0] fifo_in_data;
  logic        fifo_in_push;
  logic        fifo_in_full = 1'b0;
  logic [31:0] fifo_out_data = '0;
  logic        fifo_out_empty = 1'b1;
  logic        fifo_out_pop;
  logic        irq;

  int tests = 0;
  int fails = 0;

  csr_bank_mq dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .fifo_in_data(fifo_in_data),
    .fifo_in_push(fifo_in_push), .fifo_in_full(fifo_in_full),
    .fifo_out_data(fifo_out_data), .fifo_out_empty(fifo_out_empty),
    .fifo_out_pop(fifo_out_pop), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each access occupies one edge; returns at the following negedge
  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    rd_en = 1'b1; addr = a;
    #1 d = rdata;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [31:0] d);
    addr = a;
    #1 d = rdata;
  endtask

  logic [31:0] v;
  int          pushes;
  logic [31:0] reset_exp [8];

  initial begin
    reset_exp = '{32'h0, 32'h8, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    for (int i = 0; i < 8; i++) begin
      peek(4'(i), v);
      check($sformatf("reset_rd%0d", i), v, reset_exp[i]);
    end
    check("reset_push", fifo_in_push, 1'b0);
    check("reset_pop", fifo_out_pop, 1'b0);
    check("reset_irq", irq, 1'b0);

    // Basic command, push the cycle after the START write
    apb_write(4'd4, 32'h11);
    apb_write(4'd5, 32'h22);
    apb_write(4'd0, 32'h0000_00A7);
    check("cmd_push", fifo_in_push, 1'b1);
    check("cmd_word", fifo_in_data, {32'h22, 32'h11, 4'h5, 4'h3});
    peek(4'd0, v); check("cmd_ctrl_start", v, 32'hA7);
    peek(4'd1, v); check("cmd_busy", v, 32'h9);
    @(negedge clk);
    check("cmd_push_once", fifo_in_push, 1'b0);
    peek(4'd1, v); check("cmd_idle", v, 32'h8);

    // Stall on full, ignored DATA write raises CMD_ERR
    fifo_in_full = 1'b1;
    apb_write(4'd0, 32'h0000_00A7);
    pushes = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_in_push) pushes++;
    end
    check("stall_no_push", pushes, 0);
    peek(4'd1, v); check("stall_status", v, 32'hD);
    apb_write(4'd4, 32'h99);
    peek(4'd1, v); check("stall_cmd_err", v, 32'h1D);
    peek(4'd4, v); check("stall_data_kept", v, 32'h11);
    fifo_in_full = 1'b0;
    #1 check("release_push", fifo_in_push, 1'b1);
    check("release_data0", fifo_in_data[39:8], 32'h11);
    @(negedge clk);
    check("release_push_once", fifo_in_push, 1'b0);
    apb_write(4'd1, 32'h10);
    peek(4'd1, v); check("w1c_cmd_err", v, 32'h8);

    // AUTO_ID wrap 15 -> 0
    apb_write(4'd0, 32'h8000_01E1);
    check("auto_push1", fifo_in_push, 1'b1);
    check("auto_id15", fifo_in_data[7:4], 4'hF);
    @(negedge clk);
    peek(4'd0, v); check("auto_ctrl_wrap", v, 32'h8000_0000);
    apb_write(4'd0, 32'h8000_0001);
    check("auto_push2", fifo_in_push, 1'b1);
    check("auto_id0", fifo_in_data[7:4], 4'h0);
    @(negedge clk);
    peek(4'd0, v); check("auto_ctrl_next", v, 32'h8000_0020);

    // Result path and interrupt
    apb_write(4'd2, 32'h1);
    fifo_out_data = 32'hABCD;
    fifo_out_empty = 1'b0;
    #1 check("pop", fifo_out_pop, 1'b1);
    @(negedge clk);
    check("pop_once", fifo_out_pop, 1'b0);
    peek(4'd1, v); check("res_valid", v, 32'h2);
    check("irq_lag", irq, 1'b0);
    @(negedge clk);
    check("irq_rise", irq, 1'b1);
    fifo_out_data = 32'h1234;
    apb_read(4'd3, v);
    check("result_rd", v, 32'hABCD);
    check("pop_after_clear", fifo_out_pop, 1'b1);
    @(negedge clk);
    fifo_out_empty = 1'b1;
    apb_read(4'd3, v);
    check("result_rd2", v, 32'h1234);
    apb_read(4'd3, v);
    check("result_stale", v, 32'h1234);
    peek(4'd1, v); check("underflow", v, 32'h28);
    apb_write(4'd2, 32'h2);
    @(negedge clk);
    check("irq_err", irq, 1'b1);

    // Sticky errors, W1C of both, simultaneous wr+rd
    fifo_in_full = 1'b1;
    apb_write(4'd0, 32'h1);
    apb_write(4'd5, 32'h0);
    peek(4'd1, v); check("err_both", v, 32'h3D);
    apb_write(4'd1, 32'h30);
    peek(4'd1, v); check("w1c_both", v, 32'h0D);
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b1; addr = 4'd3; wdata = '0;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    peek(4'd1, v); check("wr_rd_suppress", v, 32'h0D);

    // Reset while pending drops the command
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fifo_in_full = 1'b0;
    #1 check("rst_no_push", fifo_in_push, 1'b0);
    peek(4'd0, v); check("rst_ctrl", v, 32'h0);
    peek(4'd1, v); check("rst_status", v, 32'h8);
    peek(4'd2, v); check("rst_irq_en", v, 32'h0);
    peek(4'd5, v); check("rst_data1", v, 32'h0);
    check("rst_irq", irq, 1'b0);
    @(negedge clk);
    check("rst_no_push_later", fifo_in_push, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
